remove_v_border: RTL and testbench
==================================

// Module: remove_v_border
// PURPOSE
// - Multi-flux vertical border stripper for HEVC 8-tap interpolation. Same flux-tagged FIFO fabric as the horizontal stripper.
// - Consumes a row-major stream of 8-pel words per flux, plus one size descriptor per block.
// - Drops the top TOP_ROWS and bottom BOT_ROWS rows of each extended block; forwards the remaining rows, tagged with their flux index.
// - Sits downstream of the horizontal border stripper; feeds the interpolation filter input FIFOs.
// PARAMETERS
// FLUX      2   number of independent tagged channels; TAG_W = $clog2(FLUX), 0 when MONO is defined
// DATA_W    18  payload width of one pel word (tag excluded)
// DIM_W     7   width of the row-count and words-per-row fields
// TOP_ROWS  3   rows dropped at block top (N_TAP/2-1)
// BOT_ROWS  4   rows dropped at block bottom (N_TAP/2)
// PORTS
// clk              in   1            clock
// rst              in   1            synchronous active-high reset
// pel_empty        in   FLUX         per-flux empty of input pel FIFO (FWFT)
// pel_dout         in   DATA_W+TAG_W head word of input pel FIFO; payload in LSBs
// pel_read         out  FLUX         one-hot pop of input pel FIFO
// size_empty       in   FLUX         per-flux empty of size FIFO (FWFT)
// size_dout        in   2*DIM_W+TAG_W {wpr[DIM_W-1:0], rows[DIM_W-1:0]} in LSBs
// size_read        out  FLUX         one-hot pop of size FIFO
// out_full         in   FLUX         per-flux full of output FIFO
// out_din          out  DATA_W+TAG_W {tag, payload}
// out_write        out  1            output push strobe
// BEHAVIOUR
// - Interface convention is fixed: reset rst is synchronous active-high, clock is clk.
// - Per-flux context registers: state (IDLE/RUN), rows, wpr, row_cnt, word_cnt (each DIM_W).
// - Reset: every state=IDLE and every counter=0.
// - Read/write strobes are combinational; with no eligible flux: pel_read=0, size_read=0, out_write=0, out_din='x.
// - Zero latency: pop and push happen in the same cycle; context updates on the next posedge.
// - drop_row(i) = (row_cnt<TOP_ROWS) | (row_cnt >= rows-BOT_ROWS). Compare is DIM_W+1 bits; when rows<BOT_ROWS the bottom bound clamps to 0.
// - Eligibility of flux i:
//   - IDLE and !size_empty[i]; or
//   - RUN and !pel_empty[i] and (drop_row(i) | !out_full[i]).
// - Arbitration: the lowest eligible index wins; at most one flux acts per cycle.
// - IDLE action: size_read[tag]=1; latch rows and wpr; clear row_cnt and word_cnt.
//   - Next state is RUN when rows!=0 and wpr!=0.
//   - Otherwise the descriptor is consumed, no pels are read, and the flux stays IDLE.
// - RUN action: pel_read[tag]=1.
//   - If !drop_row: out_write=1 and out_din={tag, pel_dout[DATA_W-1:0]}.
//   - word_cnt++. At word_cnt==wpr-1: word_cnt=0 and row_cnt++.
//   - Also at row_cnt==rows-1: state=IDLE and counters cleared.
// - A drop row never needs output space: drop-row pels are consumed while out_full is asserted.
// - A pass row stalls that flux only; other fluxes keep arbitrating.
// - A block with rows<=TOP_ROWS+BOT_ROWS forwards nothing; all rows*wpr words are consumed.
// - Reset mid-block: all fluxes return to IDLE immediately, partial-block context is discarded, and FIFO contents are not touched.
// - Fluxes never share context; tag only selects the context entry.
// TESTING
// - FLUX=2, flux0 size rows=15 wpr=2, 30 ramp words 0..29: out_write 16 times with payloads 6..21 and tag 0; flux0 ends IDLE.
// - Same block, out_full[0] held high throughout:
//   - the first 6 words are popped with no output, then pel_read stalls at word 6;
//   - after release, words 6..21 are forwarded; words 22..29 are dropped even if out_full rises again.
// - Flux0 and flux1 both loaded (rows=9 wpr=1, distinct data) and always eligible:
//   - flux0 is served first;
//   - flux1 output is rows 3..4 only, with tag 1, interleaved correctly once flux0 stalls on out_full[0].
// - rows=7 wpr=3: all 21 words are consumed, zero out_write, flux returns to IDLE, and the next size is accepted.
// - rows=0 (or wpr=0): the size word is popped, no pel_read, state stays IDLE.
// - rst asserted after 5 of 30 words: all pel_read/out_write go 0 on the next cycle; the next size word restarts row_cnt at 0.

Source files
------------

// File: rtl/remove_v_border.sv
// Vertical border stripper: drops the top/bottom interpolation margin rows of each
// block on several flux-tagged channels sharing one FIFO fabric, zero-latency.
module remove_v_border #(
    parameter int FLUX     = 2,
    parameter int DATA_W   = 18,
    parameter int DIM_W    = 7,
    parameter int TOP_ROWS = 3,
    parameter int BOT_ROWS = 4,
    localparam int TAG_W   = $clog2(FLUX)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [FLUX-1:0]           pel_empty,
    input  logic [DATA_W+TAG_W-1:0]   pel_dout,
    output logic [FLUX-1:0]           pel_read,
    input  logic [FLUX-1:0]           size_empty,
    input  logic [2*DIM_W+TAG_W-1:0]  size_dout,
    output logic [FLUX-1:0]           size_read,
    input  logic [FLUX-1:0]           out_full,
    output logic [DATA_W+TAG_W-1:0]   out_din,
    output logic                      out_write
);

    logic             run      [FLUX];
    logic [DIM_W-1:0] rows     [FLUX];
    logic [DIM_W-1:0] wpr      [FLUX];
    logic [DIM_W-1:0] row_cnt  [FLUX];
    logic [DIM_W-1:0] word_cnt [FLUX];

    logic [FLUX-1:0]  drop;
    logic [FLUX-1:0]  elig;
    logic [TAG_W-1:0] sel;
    logic             act;

    // Tag fields of the input words are informational only; the winner index is the tag.
    logic unused_tags;
    assign unused_tags = ^{pel_dout[DATA_W+TAG_W-1:DATA_W], size_dout[2*DIM_W+TAG_W-1:2*DIM_W]};

    // Bottom bound is computed one bit wider and clamps to 0 for very short blocks.
    function automatic logic drop_row(input logic [DIM_W-1:0] rc, input logic [DIM_W-1:0] rw);
        logic [DIM_W:0] bot;
        bot = ({1'b0, rw} >= (DIM_W+1)'(BOT_ROWS)) ? ({1'b0, rw} - (DIM_W+1)'(BOT_ROWS)) : '0;
        return ({1'b0, rc} < (DIM_W+1)'(TOP_ROWS)) || ({1'b0, rc} >= bot);
    endfunction

    always_comb begin
        drop = '0;
        elig = '0;
        sel  = '0;
        for (int i = 0; i < FLUX; i++) begin
            drop[i] = drop_row(row_cnt[i], rows[i]);
            elig[i] = run[i] ? (!pel_empty[i] && (drop[i] || !out_full[i])) : !size_empty[i];
        end
        for (int i = FLUX - 1; i >= 0; i--) begin
            if (elig[i]) sel = TAG_W'(i);
        end
        act = !rst && (|elig);
    end

    always_comb begin
        pel_read  = '0;
        size_read = '0;
        out_write = 1'b0;
        out_din   = 'x;
        if (act) begin
            if (!run[sel]) begin
                size_read[sel] = 1'b1;
            end else begin
                pel_read[sel] = 1'b1;
                if (!drop[sel]) begin
                    out_write = 1'b1;
                    out_din   = {sel, pel_dout[DATA_W-1:0]};
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FLUX; i++) begin
                run[i]      <= 1'b0;
                rows[i]     <= '0;
                wpr[i]      <= '0;
                row_cnt[i]  <= '0;
                word_cnt[i] <= '0;
            end
        end else if (act) begin
            if (!run[sel]) begin
                rows[sel]     <= size_dout[DIM_W-1:0];
                wpr[sel]      <= size_dout[2*DIM_W-1:DIM_W];
                row_cnt[sel]  <= '0;
                word_cnt[sel] <= '0;
                run[sel]      <= (size_dout[DIM_W-1:0] != '0) && (size_dout[2*DIM_W-1:DIM_W] != '0);
            end else if (word_cnt[sel] == wpr[sel] - DIM_W'(1)) begin
                word_cnt[sel] <= '0;
                if (row_cnt[sel] == rows[sel] - DIM_W'(1)) begin
                    run[sel]     <= 1'b0;
                    row_cnt[sel] <= '0;
                end else begin
                    row_cnt[sel] <= row_cnt[sel] + DIM_W'(1);
                end
            end else begin
                word_cnt[sel] <= word_cnt[sel] + DIM_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_remove_v_border.sv
// Bench for remove_v_border: a directed vector table plus FIFO-backed block sequences.
module tb_remove_v_border;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  pel_empty, pel_read, size_empty, size_read, out_full;
    logic [18:0] pel_dout, out_din;
    logic [14:0] size_dout;
    logic        out_write;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    remove_v_border dut (
        .clk(clk), .rst(rst),
        .pel_empty(pel_empty), .pel_dout(pel_dout), .pel_read(pel_read),
        .size_empty(size_empty), .size_dout(size_dout), .size_read(size_read),
        .out_full(out_full), .out_din(out_din), .out_write(out_write)
    );

    typedef struct {
        logic        rst;
        logic [1:0]  pe;
        logic [18:0] pd;
        logic [1:0]  se;
        logic [14:0] sd;
        logic [1:0]  of;
        logic [1:0]  e_pr;
        logic [1:0]  e_sr;
        logic        e_w;
        logic [18:0] e_d;
    } vec_t;

    vec_t vt[19];

    function automatic vec_t mk(logic r, logic [1:0] pe, logic [18:0] pd, logic [1:0] se,
                                logic [14:0] sd, logic [1:0] of, logic [1:0] e_pr,
                                logic [1:0] e_sr, logic e_w, logic [18:0] e_d);
        vec_t v;
        v.rst = r; v.pe = pe; v.pd = pd; v.se = se; v.sd = sd; v.of = of;
        v.e_pr = e_pr; v.e_sr = e_sr; v.e_w = e_w; v.e_d = e_d;
        return v;
    endfunction

    function automatic logic [13:0] sz(int w, int r);
        return {7'(w), 7'(r)};
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // FIFO models of the fabric feeding the DUT
    logic [17:0] q0[$], q1[$];
    logic [13:0] s0[$], s1[$];
    logic [18:0] cap[$];
    logic [1:0]  full_force;
    logic [1:0]  last_pel_read, last_size_read;
    logic        last_write;

    task automatic step();
        @(negedge clk);
        pel_empty  = {q1.size() == 0, q0.size() == 0};
        size_empty = {s1.size() == 0, s0.size() == 0};
        out_full   = full_force;
        pel_dout   = (q0.size() != 0) ? {1'b0, q0[0]} : '0;
        size_dout  = (s0.size() != 0) ? {1'b0, s0[0]} : '0;
        #1;
        if (pel_read[1] && q1.size() != 0) pel_dout = {1'b1, q1[0]};
        if (size_read[1] && s1.size() != 0) size_dout = {1'b1, s1[0]};
        #1;
        last_pel_read  = pel_read;
        last_size_read = size_read;
        last_write     = out_write;
        if (out_write) cap.push_back(out_din);
        if (pel_read[0] && q0.size() != 0) void'(q0.pop_front());
        if (pel_read[1] && q1.size() != 0) void'(q1.pop_front());
        if (size_read[0] && s0.size() != 0) void'(s0.pop_front());
        if (size_read[1] && s1.size() != 0) void'(s1.pop_front());
    endtask

    task automatic reset_dut();
        q0.delete(); q1.delete(); s0.delete(); s1.delete(); cap.delete();
        full_force = 2'b00;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic run(int n);
        for (int k = 0; k < n; k++) step();
    endtask

    function automatic logic [18:0] cap_at(int k);
        return (k < cap.size()) ? cap[k] : 19'h7ffff;
    endfunction

    initial begin
        rst = 1'b1; pel_empty = 2'b11; size_empty = 2'b11; out_full = 2'b00;
        pel_dout = '0; size_dout = '0; full_force = 2'b00;
        @(negedge clk);
        @(negedge clk);

        vt[0]  = mk(1, 2'b11, 0, 2'b11, 0, 2'b00, 2'b00, 2'b00, 0, 0);
        vt[1]  = mk(0, 2'b11, 0, 2'b11, 0, 2'b00, 2'b00, 2'b00, 0, 0);
        vt[2]  = mk(0, 2'b11, 0, 2'b10, {1'b0, sz(0, 5)}, 2'b00, 2'b00, 2'b01, 0, 0);
        vt[3]  = mk(0, 2'b11, 0, 2'b10, {1'b0, sz(3, 0)}, 2'b00, 2'b00, 2'b01, 0, 0);
        vt[4]  = mk(0, 2'b00, 0, 2'b11, 0, 2'b00, 2'b00, 2'b00, 0, 0);
        vt[5]  = mk(0, 2'b11, 0, 2'b00, {1'b0, sz(1, 8)}, 2'b00, 2'b00, 2'b01, 0, 0);
        vt[6]  = mk(0, 2'b11, 0, 2'b01, {1'b1, sz(1, 2)}, 2'b00, 2'b00, 2'b10, 0, 0);
        vt[7]  = mk(0, 2'b00, 19'h00011, 2'b11, 0, 2'b11, 2'b01, 2'b00, 0, 0);
        vt[8]  = vt[7];
        vt[9]  = vt[7];
        vt[10] = mk(0, 2'b00, 19'h40022, 2'b11, 0, 2'b11, 2'b10, 2'b00, 0, 0);
        vt[11] = vt[10];
        vt[12] = mk(0, 2'b00, 19'h00033, 2'b11, 0, 2'b11, 2'b00, 2'b00, 0, 0);
        vt[13] = mk(0, 2'b00, 19'h2abcd, 2'b11, 0, 2'b10, 2'b01, 2'b00, 1, 19'h2abcd);
        vt[14] = mk(0, 2'b00, 19'h00044, 2'b11, 0, 2'b11, 2'b01, 2'b00, 0, 0);
        vt[15] = vt[14];
        vt[16] = vt[14];
        vt[17] = vt[14];
        vt[18] = mk(0, 2'b00, 0, 2'b11, 0, 2'b00, 2'b00, 2'b00, 0, 0);

        for (int i = 0; i < 19; i++) begin
            @(negedge clk);
            rst = vt[i].rst; pel_empty = vt[i].pe; pel_dout = vt[i].pd;
            size_empty = vt[i].se; size_dout = vt[i].sd; out_full = vt[i].of;
            #1;
            check($sformatf("vec%0d", i),
                  {8'd0, pel_read, size_read, out_write, vt[i].e_w ? out_din : 19'd0},
                  {8'd0, vt[i].e_pr, vt[i].e_sr, vt[i].e_w, vt[i].e_d});
        end

        // Plain block: 15 rows x 2 words, rows 3..10 forwarded
        reset_dut();
        s0.push_back(sz(2, 15));
        for (int k = 0; k < 30; k++) q0.push_back(18'(k));
        run(40);
        check("a_count", cap.size(), 16);
        for (int k = 0; k < 16; k++) check($sformatf("a_word%0d", k), cap_at(k), {1'b0, 18'(6 + k)});
        s0.push_back(sz(1, 0));
        step();
        check("a_idle", last_size_read, 2'b01);

        // Same block with back-pressure on flux 0
        reset_dut();
        full_force = 2'b01;
        s0.push_back(sz(2, 15));
        for (int k = 0; k < 30; k++) q0.push_back(18'(k));
        run(20);
        check("b_stall_left", q0.size(), 24);
        check("b_stall_read", last_pel_read, 2'b00);
        check("b_stall_write", cap.size(), 0);
        full_force = 2'b00;
        for (int k = 0; k < 40 && cap.size() < 16; k++) step();
        full_force = 2'b01;
        run(20);
        check("b_drained", q0.size(), 0);
        check("b_count", cap.size(), 16);
        for (int k = 0; k < 16; k++) check($sformatf("b_word%0d", k), cap_at(k), {1'b0, 18'(6 + k)});

        // Two fluxes competing; flux0 stalls so flux1 proceeds
        reset_dut();
        full_force = 2'b01;
        s0.push_back(sz(1, 9));
        s1.push_back(sz(1, 9));
        for (int k = 0; k < 9; k++) begin
            q0.push_back(18'(100 + k));
            q1.push_back(18'(200 + k));
        end
        step();
        check("c_first", last_size_read, 2'b01);
        run(19);
        check("c_f1_count", cap.size(), 2);
        check("c_f1_w0", cap_at(0), {1'b1, 18'd203});
        check("c_f1_w1", cap_at(1), {1'b1, 18'd204});
        check("c_f0_held", q0.size(), 6);
        check("c_f1_done", q1.size(), 0);
        full_force = 2'b00;
        run(20);
        check("c_count", cap.size(), 4);
        check("c_f0_w0", cap_at(2), {1'b0, 18'd103});
        check("c_f0_w1", cap_at(3), {1'b0, 18'd104});
        check("c_f0_done", q0.size(), 0);

        // Short block forwards nothing; next descriptor accepted
        reset_dut();
        s0.push_back(sz(3, 7));
        s0.push_back(sz(1, 0));
        for (int k = 0; k < 21; k++) q0.push_back(18'(k));
        run(30);
        check("d_writes", cap.size(), 0);
        check("d_consumed", q0.size(), 0);
        check("d_next_size", s0.size(), 0);

        // Reset in the middle of a block
        reset_dut();
        s0.push_back(sz(2, 15));
        for (int k = 0; k < 30; k++) q0.push_back(18'(k));
        run(6);
        check("e_partial", q0.size(), 25);
        rst = 1'b1;
        step();
        check("e_rst_read", {last_pel_read, last_size_read, last_write}, 5'd0);
        rst = 1'b0;
        s0.push_back(sz(1, 8));
        run(12);
        check("e_count", cap.size(), 1);
        check("e_word", cap_at(0), {1'b0, 18'd8});
        check("e_left", q0.size(), 17);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
